// File: rtl/kes_channel_arbiter.sv
// Shares one key-equation solver among Channel requesters, issuing one cluster
// (Multi chunks) at a time. Define KES_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module kes_channel_arbiter #(
    parameter int Channel = 4,
    parameter int Multi   = 2,
    localparam int CW     = (Multi > 1) ? $clog2(Multi) : 1,
    localparam int PW     = (Channel > 1) ? $clog2(Channel) : 1
) (
    input  logic                       iClock,
    input  logic                       iReset,
    input  logic [Channel*Multi-1:0]   iErrorDetectionEnd,
    input  logic [Channel*Multi-1:0]   iDecodeNeeded,
    output logic [Channel-1:0]         oSharedKESReady,
    input  logic                       iKESAvailable,
    output logic                       oExecuteKES,
    output logic                       oDataFowarding,
    output logic [CW-1:0]              oChunkNumber,
    output logic                       oLastChunk,
    output logic [Channel-1:0]         oChannelSel,
    output logic [1:0]                 oDbgState
);

    // Handshake: a channel may present a cluster (one cycle of iErrorDetectionEnd
    // with any bit set) only while oSharedKESReady[c]=1; the cluster is owned by the
    // arbiter until RELEASE. Each chunk is issued only when iKESAvailable=1.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_GAP     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_CHUNK = CW'(Multi - 1);

    state_t                     state_q, state_d;
    logic [Channel-1:0]         pend_q, pend_d;
    logic [Channel*Multi-1:0]   need_q, need_d;
    logic [CW-1:0]              chunk_q, chunk_d;
    logic [Channel-1:0]         sel_q, sel_d;
    logic [PW-1:0]              gidx_q, gidx_d;
    logic                       exec_q, exec_d;
    logic                       fwd_q, fwd_d;
    logic [CW-1:0]              num_q, num_d;
    logic                       last_q, last_d;

    logic                       win_found;
    logic [PW-1:0]              win_idx;
    logic [2*Channel-1:0]       pend_rot;
    logic [Multi-1:0]           need_row;

`ifndef KES_ARB_FIXED_PRIORITY_EN
    logic [PW-1:0]              ptr_q, ptr_d;
`endif

    // Winner search: pending bits rotated so the search always starts at bit 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef KES_ARB_FIXED_PRIORITY_EN
        pend_rot  = {pend_q, pend_q};
        for (int i = 0; i < Channel; i++) begin
            if (!win_found && pend_rot[i]) begin
                win_found = 1'b1;
                win_idx   = PW'(i);
            end
        end
`else
        pend_rot  = {pend_q, pend_q} >> ptr_q;
        for (int i = 0; i < Channel; i++) begin
            if (!win_found && pend_rot[i]) begin
                win_found = 1'b1;
                win_idx   = PW'((int'(ptr_q) + i) % Channel);
            end
        end
`endif
    end

    always_comb begin
        need_row = '0;
        for (int c = 0; c < Channel; c++) begin
            if (gidx_q == PW'(c)) need_row = need_q[c*Multi +: Multi];
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        need_d  = need_q;
        chunk_d = chunk_q;
        sel_d   = sel_q;
        gidx_d  = gidx_q;
        exec_d  = 1'b0;
        fwd_d   = 1'b0;
        num_d   = '0;
        last_d  = 1'b0;
`ifndef KES_ARB_FIXED_PRIORITY_EN
        ptr_d   = ptr_q;
`endif

        // Capture is blind to FSM state; a pending channel ignores its inputs.
        for (int c = 0; c < Channel; c++) begin
            if (!pend_q[c] && |iErrorDetectionEnd[c*Multi +: Multi]) begin
                pend_d[c]                = 1'b1;
                need_d[c*Multi +: Multi] = iDecodeNeeded[c*Multi +: Multi];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    for (int c = 0; c < Channel; c++) sel_d[c] = (win_idx == PW'(c));
                    gidx_d  = win_idx;
                    chunk_d = '0;
                    state_d = S_ISSUE;
`ifndef KES_ARB_FIXED_PRIORITY_EN
                    ptr_d   = (int'(win_idx) == Channel - 1) ? '0 : win_idx + 1'b1;
`endif
                end
            end
            S_ISSUE: begin
                if (iKESAvailable) begin
                    exec_d  = need_row[chunk_q];
                    fwd_d   = !need_row[chunk_q];
                    num_d   = chunk_q;
                    last_d  = (chunk_q == LAST_CHUNK);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // The solver drops iKESAvailable a cycle late; skip that cycle.
                if (chunk_q == LAST_CHUNK) begin
                    state_d = S_RELEASE;
                end else begin
                    chunk_d = chunk_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_RELEASE: begin
                for (int c = 0; c < Channel; c++) begin
                    if (gidx_q == PW'(c)) pend_d[c] = 1'b0;
                end
                sel_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            need_q  <= '0;
            chunk_q <= '0;
            sel_q   <= '0;
            gidx_q  <= '0;
            exec_q  <= 1'b0;
            fwd_q   <= 1'b0;
            num_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            need_q  <= need_d;
            chunk_q <= chunk_d;
            sel_q   <= sel_d;
            gidx_q  <= gidx_d;
            exec_q  <= exec_d;
            fwd_q   <= fwd_d;
            num_q   <= num_d;
            last_q  <= last_d;
        end
    end

`ifndef KES_ARB_FIXED_PRIORITY_EN
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end
`endif

    assign oSharedKESReady = ~pend_q;
    assign oExecuteKES     = exec_q;
    assign oDataFowarding  = fwd_q;
    assign oChunkNumber    = num_q;
    assign oLastChunk      = last_q;
    assign oChannelSel     = sel_q;
    assign oDbgState       = state_q;

endmodule

// File: tb/tb_kes_channel_arbiter.sv
// Scoreboard bench for kes_channel_arbiter (Channel=4, Multi=2): expected pulses
// are queued at stimulus time and popped by a monitor whenever a pulse appears.
module tb_kes_channel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] det_r;
  logic [7:0] dn_r;
  logic       avail;
  logic [3:0] ready;
  logic       exec;
  logic       fwd;
  logic [0:0] chunk;
  logic       last;
  logic [3:0] sel;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  kes_channel_arbiter #(.Channel(4), .Multi(2)) dut (
    .iClock             (clk),
    .iReset             (rst_n),
    .iErrorDetectionEnd (det_r),
    .iDecodeNeeded      (dn_r),
    .oSharedKESReady    (ready),
    .iKESAvailable      (avail),
    .oExecuteKES        (exec),
    .oDataFowarding     (fwd),
    .oChunkNumber       (chunk),
    .oLastChunk         (last),
    .oChannelSel        (sel),
    .oDbgState          (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mk(input logic e, input logic f, input logic l,
                                    input logic c, input logic [3:0] s);
    return {e, f, l, c, s};
  endfunction

  // driver tasks (all called at a negedge)
  task automatic do_reset();
    rst_n = 1'b0;
    det_r = '0;
    dn_r  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] det, input logic [7:0] dn);
    det_r = det;
    dn_r  = dn;
    @(negedge clk);
    det_r = '0;
    dn_r  = '0;
  endtask

  task automatic wait_sel(input logic [3:0] val, input string name);
    int n = 0;
    while (sel !== val && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, sel, val);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (exec || fwd) begin
        if (exp_q.size() == 0) check("unexpected_pulse", {exec, fwd, last, chunk, sel}, 0);
        else                   check("pulse", {exec, fwd, last, chunk, sel}, exp_q.pop_front());
      end else begin
        check("idle_qualifiers", {last, chunk}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    det_r = '0;
    dn_r  = '0;
    avail = 1'b1;
    @(negedge clk);
    check("reset_ready", ready, 4'b1111);
    check("reset_sel", sel, 4'b0000);
    check("reset_pulses", {exec, fwd, last, chunk}, 0);
    do_reset();

    // quiet after reset
    for (int i = 0; i < 20; i++) begin
      check("idle_ready", ready, 4'b1111);
      check("idle_sel", sel, 4'b0000);
      @(negedge clk);
    end

    // ch1: det 11, need 10 -> forward chunk 0, execute chunk 1
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'b0010));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 4'b0010));
    drive(8'b00_00_11_00, 8'b00_00_10_00);
    check("ch1_captured_ready", ready, 4'b1101);
    wait_sel(4'b0010, "ch1_grant");
    wait_drain("ch1_drain");
    repeat (3) @(negedge clk);
    check("ch1_ready_back", ready, 4'b1111);
    check("ch1_sel_cleared", sel, 4'b0000);

    // ch0, ch2, ch3 together from a fresh pointer -> 0, 2, 3
    do_reset();
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 4'b0001));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'b0100));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 4'b0100));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b1000));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 4'b1000));
    drive(8'b11_10_00_01, 8'b11_00_00_01);
    check("multi_ready", ready, 4'b0010);
    wait_sel(4'b1000, "ch3_grant");
    // ch0 re-requests while ch3 is active -> wraps to ch0
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'b0001));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 4'b0001));
    drive(8'b00_00_00_01, 8'b00_00_00_10);
    wait_drain("wrap_drain");
    repeat (3) @(negedge clk);

    // ch2 active, then ch0 and ch3 pending
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'b0100));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 4'b0100));
    drive(8'b00_01_00_00, 8'b00_00_00_00);
    wait_sel(4'b0100, "ch2_grant");
`ifdef KES_ARB_FIXED_PRIORITY_EN
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 4'b0001));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'b1000));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 4'b1000));
`else
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'b1000));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 4'b1000));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 4'b0001));
`endif
    drive(8'b10_00_00_10, 8'b00_00_00_11);
    wait_drain("order_drain");
    repeat (3) @(negedge clk);

    // solver busy for 10 cycles while ch1 is in ISSUE
    avail = 1'b0;
    drive(8'b00_00_01_00, 8'b00_00_01_00);
    wait_sel(4'b0010, "stall_grant");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_sel", sel, 4'b0010);
      check("stall_no_pulse", {exec, fwd}, 2'b00);
    end
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0010));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 4'b0010));
    avail = 1'b1;
    @(negedge clk);
    check("pulse_after_avail", exec, 1'b1);
    wait_drain("stall_drain");
    repeat (3) @(negedge clk);

    // reset during GAP of chunk 0 abandons the cluster
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0100));
    drive(8'b00_11_00_00, 8'b00_11_00_00);
    begin
      int n = 0;
      while (exec !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("gap_reached", exec, 1'b1);
    end
    #1 rst_n = 1'b0;
    #1;
    check("rst_pulses", {exec, fwd, last, chunk}, 0);
    check("rst_sel", sel, 4'b0000);
    check("rst_ready", ready, 4'b1111);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_queue_empty", exp_q.size(), 0);
    check("rst_sel_after", sel, 4'b0000);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kes_channel_arbiter.md
KES_CHANNEL_ARBITER -- requirements
Module: kes_channel_arbiter

Interface
REQ-001 SHALL have parameter Channel, default 4, number of requesting channels.
REQ-002 SHALL have parameter Multi, default 2, chunks per cluster; chunk index width CW = clog2(Multi), minimum 1.
REQ-003 SHALL have port iClock, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port iReset, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port iErrorDetectionEnd, input, Channel*Multi: per-channel per-chunk detection-done flags; slice c = bits [c*Multi +: Multi].
REQ-006 SHALL have port iDecodeNeeded, input, Channel*Multi: per-chunk decode-needed flags, same slicing.
REQ-007 SHALL have port oSharedKESReady, output, Channel: channel c may present a cluster.
REQ-008 SHALL have port iKESAvailable, input, 1: shared KES accepts a chunk this cycle.
REQ-009 SHALL have port oExecuteKES, output, 1: one-cycle pulse, run KES on current chunk.
REQ-010 SHALL have port oDataFowarding, output, 1: one-cycle pulse, forward clean chunk without solving.
REQ-011 SHALL have port oChunkNumber, output, CW: chunk index qualified by either pulse.
REQ-012 SHALL have port oLastChunk, output, 1: qualified by either pulse, marks final chunk of the cluster.
REQ-013 SHALL have port oChannelSel, output, Channel: one-hot granted channel, zero when idle.

Function
REQ-014 SHALL hold per-channel pending bit P[c] and need mask N[c] (Multi bits); oSharedKESReady[c] SHALL equal ~P[c] combinationally.
REQ-015 Capture: when P[c]=0 and any bit of iErrorDetectionEnd slice c is 1, SHALL set P[c]=1 and N[c]=iDecodeNeeded slice c at that edge; inputs ignored while P[c]=1.
REQ-016 FSM states IDLE, ISSUE, GAP, RELEASE; reset state IDLE.
REQ-017 IDLE: if any P set, SHALL register the winner into oChannelSel, clear chunk counter to 0, go ISSUE; else stay.
REQ-018 Arbitration SHALL be round-robin: search starts at channel after the previously granted one, wrapping Channel-1 -> 0; after reset search starts at channel 0.
REQ-019 ISSUE: while iKESAvailable=0 SHALL hold with no pulse; when 1, SHALL pulse next cycle oExecuteKES if N[grant][chunk]=1 else oDataFowarding, never both, with oChunkNumber=chunk, oLastChunk=(chunk==Multi-1), then go GAP.
REQ-020 GAP: exactly one cycle, masking the registered iKESAvailable deassertion; then if last chunk go RELEASE, else increment chunk and go ISSUE.
REQ-021 RELEASE: SHALL clear P[grant], zero oChannelSel, go IDLE; oSharedKESReady[grant] returns to 1 next cycle.
REQ-022 A cluster with N all zero SHALL still issue Multi oDataFowarding pulses.
REQ-023 Capture on non-granted channels SHALL proceed in any state; capture and grant in the same cycle SHALL not occur for one channel (grant needs P=1 beforehand).
REQ-024 oChannelSel SHALL stay constant from ISSUE entry through GAP of last chunk.
REQ-025 Pulse outputs SHALL be registered; oChunkNumber/oLastChunk SHALL be 0 when no pulse.

Reset
REQ-026 On iReset low, immediately: P, N, chunk counter, round-robin pointer = 0; FSM = IDLE; oExecuteKES, oDataFowarding, oLastChunk, oChunkNumber, oChannelSel = 0; oSharedKESReady = all ones.
REQ-027 Reset mid-cluster SHALL abandon the cluster without any further pulse; it is not resumed.

Configuration
REQ-028 Macro KES_ARB_FIXED_PRIORITY_EN: defined -> winner is lowest-index pending channel, pointer unused; undefined -> round-robin per REQ-018.

Verification
REQ-029 Reset release, no requests -> oSharedKESReady=4'b1111, oChannelSel=0, no pulses for 20 cycles.
REQ-030 Ch1 presents ErrorDetectionEnd=2'b11, DecodeNeeded=2'b10, KES always available -> oChannelSel=4'b0010; oDataFowarding chunk 0 LastChunk 0; then oExecuteKES chunk 1 LastChunk 1; ready[1] back to 1 after RELEASE.
REQ-031 Ch0, ch2, ch3 request same cycle -> grants in order 0,2,3; then ch0 re-requests while ch3 active -> ch0 granted next (wrap).
REQ-032 iKESAvailable held 0 for 10 cycles in ISSUE -> no pulse, oChannelSel stable; pulse one cycle after iKESAvailable rises.
REQ-033 iReset asserted during GAP of chunk 0 -> all outputs zero immediately, ready 4'b1111, no chunk-1 pulse after release.
REQ-034 With KES_ARB_FIXED_PRIORITY_EN, ch3 active and ch0, ch2 pending -> ch0 granted before ch2.
